// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine credit path.
// Contents: bus widths, controller state enum, last_win codes, jackpot value,
// and the double-dabble digit adjust used by the BCD converter.
package slot_pkg;

    localparam int unsigned CREDIT_W = 10;  // credit count and spinner result width
    localparam int unsigned CALC_W   = 11;  // credit arithmetic width (headroom before clamp)
    localparam int unsigned BCD_W    = 12;  // three BCD digits
    localparam int unsigned TIMER_W  = 32;

    localparam int unsigned JACKPOT_VALUE = 777;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RUN,
        WAIT_STOP,
        EVAL,
        PAYOUT
    } state_t;

    typedef enum logic [1:0] {
        LOSS    = 2'd0,
        WIN     = 2'd1,
        JACKPOT = 2'd2
    } win_t;

    // Add 3 to the ones and tens digits when they are >= 5. The hundreds digit
    // is never >= 5 before the final shift because the input is at most 999,
    // so only its low three bits are carried here.
    function automatic logic [BCD_W-2:0] dabble_adjust(input logic [BCD_W-2:0] a);
        logic [BCD_W-2:0] r;
        r = a;
        for (int i = 0; i < 2; i++) begin
            if (a[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/credit_controller_if.sv
// Spin handshake between the credit controller and the spinner mode block.
// start : controller -> spinner, one-clk spin request
// pause : spinner -> controller, 1 = idle/stopped, 0 = spinning
// won   : spinner -> controller, result flag valid when pause returns to 1
// out   : spinner -> controller, result value 0..999, valid with won
interface credit_controller_if;
    import slot_pkg::*;

    logic                start;
    logic                pause;
    logic                won;
    logic [CREDIT_W-1:0] out;

    modport master (output start, input pause, input won, input out);
    modport slave  (input start, output pause, output won, output out);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble, 10-bit binary to 3 BCD digits.
// clk, rst : clock, synchronous active-high reset
// load     : capture bin and (re)start; one load cycle then 10 shift cycles
// bin      : binary value, at most 999
// bcd      : last completed result {hundreds, tens, ones}, held while converting
// done     : 1 when bcd holds the conversion of the most recent load
module bin2bcd_seq
    import slot_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] bin,
    output logic [BCD_W-1:0]    bcd,
    output logic                done
);

    logic [CREDIT_W-1:0] shift_q;
    logic [BCD_W-2:0]    acc_q;
    logic [3:0]          cnt_q;
    logic [BCD_W-1:0]    acc_step;

    // One adjust-then-shift step, pulling in the next binary MSB.
    always_comb begin
        acc_step = {dabble_adjust(acc_q), shift_q[CREDIT_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else if (load) begin
            shift_q <= bin;
            acc_q   <= '0;
            cnt_q   <= 4'(CREDIT_W);
            done    <= 1'b0;
        end else if (cnt_q != 4'd0) begin
            acc_q   <= acc_step[BCD_W-2:0];
            shift_q <= {shift_q[CREDIT_W-2:0], 1'b0};
            cnt_q   <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                bcd  <= acc_step;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_controller.sv
// Player-side end of the spin interface: credit bank, bet/spin/payout FSM and
// BCD credit display feed.
// clk, rst      : 50 MHz clock, synchronous active-high reset
// coin, play    : button levels, rising edges add a credit / request a spin
// spin          : handshake to the spinner (start out; pause, won, out in)
// credits       : binary credit count
// credit_bcd    : credits as {hundreds, tens, ones}; bcd_valid when current
// busy          : FSM not idle; payout_active : FSM paying out
// last_win      : 0 loss, 1 win, 2 jackpot; coin_reject : coin refused at max
module credit_controller
    import slot_pkg::*;
#(
    parameter int unsigned MAX_CREDITS    = 999,
    parameter int unsigned BET            = 1,
    parameter int unsigned WIN_PAYOUT     = 10,
    parameter int unsigned JACKPOT_PAYOUT = 50,
    parameter int unsigned PAY_TICKS      = 5_000_000,
    parameter int unsigned RUN_TIMEOUT    = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin,
    input  logic                play,
    credit_controller_if.master spin,
    output logic [CREDIT_W-1:0] credits,
    output logic [BCD_W-1:0]    credit_bcd,
    output logic                bcd_valid,
    output logic                busy,
    output logic                payout_active,
    output logic [1:0]          last_win,
    output logic                coin_reject
);

    localparam logic [CALC_W-1:0]  MAX_C    = CALC_W'(MAX_CREDITS);
    localparam logic [CALC_W-1:0]  BET_C    = CALC_W'(BET);
    localparam logic [TIMER_W-1:0] RUN_LAST = TIMER_W'(RUN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PAY_LAST = TIMER_W'(PAY_TICKS - 1);

    state_t              state, state_nxt;
    logic                pause_s1, pause_s2, won_s1, won_s2;
    logic [CREDIT_W-1:0] out_s1, out_s2;
    logic                coin_prev, play_prev, coin_edge, play_edge;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [CREDIT_W-1:0] award, award_nxt, credits_nxt;
    logic [1:0]          last_win_nxt;
    logic                debit, refund, pay_tick, coin_reject_nxt;
    logic [CALC_W-1:0]   sum;
    logic                start_q, bcd_init, bcd_load;

    assign spin.start = start_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, award/timer updates and saturating credit arithmetic.
    always_comb begin
        coin_edge       = coin & ~coin_prev;
        play_edge       = play & ~play_prev;
        state_nxt       = state;
        timer_nxt       = timer;
        award_nxt       = award;
        last_win_nxt    = last_win;
        debit           = 1'b0;
        refund          = 1'b0;
        pay_tick        = 1'b0;
        coin_reject_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (play_edge && (CALC_W'(credits) >= BET_C)) begin
                    debit     = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                timer_nxt = '0;
                state_nxt = WAIT_RUN;
            end
            WAIT_RUN: begin
                if (!pause_s2) begin
                    state_nxt = WAIT_STOP;
                end else if (timer >= RUN_LAST) begin
                    refund    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            WAIT_STOP: begin
                if (pause_s2) state_nxt = EVAL;
            end
            EVAL: begin
                timer_nxt = '0;
                if (!won_s2) begin
                    award_nxt    = '0;
                    last_win_nxt = LOSS;
                end else if (out_s2 == CREDIT_W'(JACKPOT_VALUE)) begin
                    award_nxt    = CREDIT_W'(JACKPOT_PAYOUT);
                    last_win_nxt = JACKPOT;
                end else begin
                    award_nxt    = CREDIT_W'(WIN_PAYOUT);
                    last_win_nxt = WIN;
                end
                state_nxt = (award_nxt != '0) ? PAYOUT : IDLE;
            end
            PAYOUT: begin
                if (award == '0) begin
                    state_nxt = IDLE;
                end else if (timer >= PAY_LAST) begin
                    pay_tick  = 1'b1;
                    timer_nxt = '0;
                    award_nxt = award - CREDIT_W'(1);
                    if (award_nxt == '0) state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Debit is taken against the pre-coin value; the coin is applied last so
        // coin_reject reflects only whether the coin itself was refused.
        sum = CALC_W'(credits);
        if (debit)    sum = sum - BET_C;
        if (refund)   sum = sum + BET_C;
        if (pay_tick) sum = sum + CALC_W'(1);
        if (sum > MAX_C) sum = MAX_C;
        if (coin_edge) begin
            if (sum >= MAX_C) coin_reject_nxt = 1'b1;
            else              sum = sum + CALC_W'(1);
        end
        credits_nxt = CREDIT_W'(sum);

        // Reaching the ceiling mid-payout forfeits whatever award remains.
        if ((state == PAYOUT) && (sum == MAX_C)) begin
            award_nxt = '0;
            state_nxt = IDLE;
        end

        bcd_load = bcd_init | (credits_nxt != credits);
    end

    // Synchronisers, edge registers, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_s1      <= 1'b1;
            pause_s2      <= 1'b1;
            won_s1        <= 1'b0;
            won_s2        <= 1'b0;
            out_s1        <= '0;
            out_s2        <= '0;
            coin_prev     <= 1'b0;
            play_prev     <= 1'b0;
            timer         <= '0;
            award         <= '0;
            credits       <= '0;
            last_win      <= '0;
            coin_reject   <= 1'b0;
            start_q       <= 1'b0;
            busy          <= 1'b0;
            payout_active <= 1'b0;
            bcd_init      <= 1'b1;
        end else begin
            pause_s1      <= spin.pause;
            pause_s2      <= pause_s1;
            won_s1        <= spin.won;
            won_s2        <= won_s1;
            out_s1        <= spin.out;
            out_s2        <= out_s1;
            coin_prev     <= coin;
            play_prev     <= play;
            timer         <= timer_nxt;
            award         <= award_nxt;
            credits       <= credits_nxt;
            last_win      <= last_win_nxt;
            coin_reject   <= coin_reject_nxt;
            start_q       <= (state_nxt == ARM);
            busy          <= (state_nxt != IDLE);
            payout_active <= (state_nxt == PAYOUT);
            bcd_init      <= 1'b0;
        end
    end

    bin2bcd_seq u_bcd (
        .clk  (clk),
        .rst  (rst),
        .load (bcd_load),
        .bin  (credits_nxt),
        .bcd  (credit_bcd),
        .done (bcd_valid)
    );

endmodule

// File: tb/tb_credit_controller.sv
// Self-checking bench for credit_controller with a behavioural spinner and a
// credit-count reference model (PAY_TICKS=4, RUN_TIMEOUT=20).
module tb_credit_controller;
    import slot_pkg::*;

    localparam int PAY = 4;
    localparam int TMO = 20;
    localparam int MAXC = 999;

    logic        clk;
    logic        rst;
    logic        coin;
    logic        play;
    logic [9:0]  credits;
    logic [11:0] credit_bcd;
    logic        bcd_valid, busy, payout_active, coin_reject;
    logic [1:0]  last_win;

    int compared   = 0;
    int mismatched = 0;
    int model_credits = 0;
    int model_last_win = 0;

    credit_controller_if spin_if ();

    credit_controller #(
        .MAX_CREDITS(999), .BET(1), .WIN_PAYOUT(10), .JACKPOT_PAYOUT(50),
        .PAY_TICKS(PAY), .RUN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .coin(coin), .play(play), .spin(spin_if),
        .credits(credits), .credit_bcd(credit_bcd), .bcd_valid(bcd_valid),
        .busy(busy), .payout_active(payout_active), .last_win(last_win),
        .coin_reject(coin_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bcd_of(input int v);
        return 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic insert_coin();
        bit rej;
        rej = (model_credits >= MAXC);
        coin = 1'b1;
        @(negedge clk);
        check("coin_reject", 32'(coin_reject), 32'(rej));
        if (!rej) model_credits++;
        check("coin_credits", 32'(credits), 32'(model_credits));
        coin = 1'b0;
        @(negedge clk);
        if (!rej) check("bcd_drop", 32'(bcd_valid), 32'd0);
    endtask

    task automatic check_bcd();
        int n;
        n = 0;
        while (!bcd_valid && n < 11) begin
            @(negedge clk);
            n++;
        end
        check("bcd_valid", 32'(bcd_valid), 32'd1);
        check("credit_bcd", 32'(credit_bcd), bcd_of(model_credits));
    endtask

    // One full spin; the spinner is modelled here. coin_tick lands a coin edge
    // on the second payout increment.
    task automatic do_spin(input bit won_v, input logic [9:0] out_v, input int run_len,
                           input bit coin_tick);
        int exp_award, exp_lw, exp_final, n, n_final, last_chg, prev;
        bit saw_payout, coin_done;
        exp_award = !won_v ? 0 : ((out_v == 10'd777) ? 50 : 10);
        exp_lw    = !won_v ? 0 : ((out_v == 10'd777) ? 2 : 1);
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        model_credits--;
        check("start_pulse", 32'(spin_if.start), 32'd1);
        check("bet_debit", 32'(credits), 32'(model_credits));
        @(negedge clk);
        check("start_width", 32'(spin_if.start), 32'd0);
        spin_if.pause = 1'b0;
        play = 1'b1;            // play edge while busy must be ignored
        @(negedge clk);
        play = 1'b0;
        repeat (run_len - 1) @(negedge clk);
        check("busy_spinning", 32'(busy), 32'd1);
        spin_if.won   = won_v;
        spin_if.out   = out_v;
        spin_if.pause = 1'b1;
        exp_final = model_credits + exp_award + (coin_tick ? 1 : 0);
        if (exp_final > MAXC) exp_final = MAXC;
        prev = int'(credits);
        n = 0; n_final = -1; last_chg = -1; saw_payout = 0; coin_done = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
            if (payout_active) saw_payout = 1;
            if (int'(credits) != prev) begin
                if (last_chg >= 0) check("tick_spacing", 32'(n - last_chg), 32'(PAY));
                check("tick_step", 32'(credits), 32'(prev + 1));
                prev = int'(credits);
                last_chg = n;
                if (coin_tick && !coin_done && busy) begin
                    coin_done = 1;
                    repeat (PAY - 1) @(negedge clk);
                    coin = 1'b1;
                    @(negedge clk);
                    coin = 1'b0;
                    n += PAY;
                    check("coin_plus_tick", 32'(credits), 32'(prev + 2));
                    prev = int'(credits);
                    last_chg = n;
                end
            end
            if (n_final < 0 && int'(credits) == exp_final) n_final = n;
        end
        check("spin_done", 32'(busy), 32'd0);
        check("final_credits", 32'(credits), 32'(exp_final));
        check("last_win", 32'(last_win), 32'(exp_lw));
        check("payout_idle", 32'(payout_active), 32'd0);
        check("payout_seen", 32'(saw_payout), 32'(exp_award > 0));
        if (exp_award > 0) check("payout_exit_at_final", 32'(n), 32'(n_final));
        model_credits  = exp_final;
        model_last_win = exp_lw;
    endtask

    initial begin
        int n;
        bit any_start;
        logic [9:0] out_v;
        rst = 1'b1; coin = 1'b0; play = 1'b0;
        spin_if.pause = 1'b1; spin_if.won = 1'b0; spin_if.out = '0;
        repeat (3) @(negedge clk);
        check("rst_credits", 32'(credits), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(spin_if.start), 32'd0);
        check("rst_payout", 32'(payout_active), 32'd0);
        check("rst_last_win", 32'(last_win), 32'd0);
        check("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        check("rst_coin_reject", 32'(coin_reject), 32'd0);
        rst = 1'b0;
        check_bcd();

        // Play with no credits: no start.
        any_start = 0;
        play = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            play = 1'b0;
            if (spin_if.start || busy) any_start = 1;
        end
        check("no_start_zero_credits", 32'(any_start), 32'd0);

        // Spinner never starts: timeout refunds the bet after 20 clks in WAIT_RUN.
        insert_coin();
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        check("tmo_start", 32'(spin_if.start), 32'd1);
        check("tmo_debit", 32'(credits), 32'(model_credits - 1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check("tmo_cycles", 32'(n), 32'(TMO + 1));
        check("tmo_refund", 32'(credits), 32'(model_credits));
        check("tmo_last_win", 32'(last_win), 32'(model_last_win));

        insert_coin();
        insert_coin();
        check_bcd();

        do_spin(1'b0, 10'd0, 50, 1'b0);
        do_spin(1'b1, 10'd333, 50, 1'b0);
        out_v = 10'($urandom_range(0, 999));
        if (out_v == 10'd777) out_v = 10'd123;
        do_spin(1'b1, out_v, 30, 1'b0 | 1'b1);

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            out_v = ($urandom_range(0, 2) == 0) ? 10'd777 : 10'($urandom_range(0, 999));
            do_spin(1'($urandom_range(0, 1)), out_v, $urandom_range(3, 40), 1'b0);
        end

        // Reset in the middle of a payout discards the remaining award.
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        @(negedge clk);
        spin_if.pause = 1'b0;
        repeat (10) @(negedge clk);
        spin_if.won = 1'b1; spin_if.out = 10'd5; spin_if.pause = 1'b1;
        n = 0;
        while (!payout_active && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("payout_reached", 32'(payout_active), 32'd1);
        repeat (PAY + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_credits", 32'(credits), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(spin_if.start), 32'd0);
        check("mid_rst_payout", 32'(payout_active), 32'd0);
        rst = 1'b0;
        model_credits = 0;
        model_last_win = 0;
        repeat (3 * PAY) @(negedge clk);
        check("award_discarded", 32'(credits), 32'd0);
        check("post_rst_idle", 32'(busy), 32'd0);

        // Jackpot near the ceiling: 980 -> bet 979 -> stops at 999.
        while (model_credits < 980) insert_coin();
        check_bcd();
        do_spin(1'b1, 10'd777, 20, 1'b0);
        check_bcd();
        insert_coin();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/credit_controller.md
Name: credit_controller

Overview:
- Player-side end of the spin interface: owns the credit bank, converts a PLAY request into a start pulse for the spinner, and waits for the spin to finish.
- On completion it samples the spinner's `won`/`out` result and pays credits out one tick at a time.
- Feeds a 3-digit BCD credit display.
- Sits between the button/coin inputs and the spinner mode block in the slot-machine top level.

Parameters:
- MAX_CREDITS, 999, saturation ceiling of the credit bank (≤ 1023).
- BET, 1, credits debited per spin.
- WIN_PAYOUT, 10, credits awarded when `won`=1 and `out`≠777.
- JACKPOT_PAYOUT, 50, credits awarded when `won`=1 and `out`=777.
- PAY_TICKS, 5_000_000, clk cycles between payout increments (10 Hz at 50 MHz).
- RUN_TIMEOUT, 10_000_000, clk cycles to wait for the spinner to drop `pause` before aborting.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- coin  in  1  coin-insert level; rising edge adds 1 credit.
- play  in  1  play-button level; rising edge requests a spin.
- pause  in  1  from spinner; 1 = idle/stopped, 0 = spinning.
- won  in  1  from spinner; valid when `pause` returns to 1.
- out  in  10  spinner result (0..999); valid with `won`.
- start  out  1  one-clk pulse to spinner.
- credits  out  10  current credit count (binary).
- credit_bcd  out  12  credits as 3 BCD digits, {hundreds, tens, ones}.
- bcd_valid  out  1  `credit_bcd` matches `credits`.
- busy  out  1  state ≠ IDLE.
- payout_active  out  1  state = PAYOUT.
- last_win  out  2  0 = loss, 1 = win, 2 = jackpot; updated in EVAL.
- coin_reject  out  1  one-clk pulse when a coin is refused at saturation.

Behaviour:
- **Reset (sync, active-high).** All outputs 0; credits=0; state IDLE; edge registers cleared. Reset mid-spin or mid-payout discards the pending award.
- **Input synchronisation.** `pause`/`won`/`out` come from the slow divided-clock domain. Each passes through a 2-FF synchroniser; `pause` sync flops reset to 1.
- **Edge detection.** `coin`/`play` use a registered previous value; the edge is `cur & ~prev`.
- **Coin.** Accepted in any state.
  - credits+1, or credits unchanged plus `coin_reject` when credits=MAX_CREDITS.
- **FSM.**
  - IDLE: on a `play` edge with credits ≥ BET, go to ARM and debit credits -= BET. If credits < BET, the play edge is ignored.
  - ARM: `start`=1 for exactly this cycle; go to WAIT_RUN and clear the timer.
  - WAIT_RUN: synced `pause`=0 → WAIT_STOP. If the timer reaches RUN_TIMEOUT, refund BET (saturating) and return to IDLE; `last_win` is unchanged.
  - WAIT_STOP: synced `pause`=1 → EVAL. There is no timeout; the spinner guarantees a stop.
  - EVAL (1 cycle): latch the award.
    - won=0 → award 0, `last_win`=0.
    - won=1 and out=777 → JACKPOT_PAYOUT, `last_win`=2.
    - otherwise WIN_PAYOUT, `last_win`=1.
    - Then go to PAYOUT if award>0, else IDLE.
  - PAYOUT: every PAY_TICKS cycles, credits+1 and award-1. Exit to IDLE when award=0.
    - If credits reach MAX_CREDITS, the remaining award is forfeited and the block exits immediately.
- **Play edges while busy** are ignored.
- **Simultaneous coin and payout increment** in the same cycle: credits + 2, saturated at MAX_CREDITS; `coin_reject` fires only if the coin itself added nothing.
- **Simultaneous coin and bet debit** in IDLE: net credits+1-BET; the debit is checked against the pre-coin value.
- **Widths.** Credits arithmetic is done 11 bits wide, then clamped; no wrap-around permitted. Timers are 32-bit.
- **BCD.**
  - Any change of `credits` restarts the conversion and drops `bcd_valid` the next cycle.
  - The conversion completes 11 cycles after its last restart; `credit_bcd` then updates and `bcd_valid` goes to 1.
  - `credit_bcd` holds its old value while converting.

Decomposition:
- Package `slot_pkg`:
  - state enum {IDLE, ARM, WAIT_RUN, WAIT_STOP, EVAL, PAYOUT};
  - `last_win` codes LOSS=0, WIN=1, JACKPOT=2;
  - constant JACKPOT_VALUE=777.
- One sub-module: `bin2bcd_seq`, a sequential double-dabble (10-bit in, 12-bit out).
  - Handshake: `load` in, `done` out.
  - 10 shift cycles + 1 load cycle.

Test Plan (PAY_TICKS=4, RUN_TIMEOUT=20, spinner modelled by bench):
- Reset, 3 coin edges → credits=3; `bcd_valid`=1 within 11 clks with `credit_bcd`=12'h003.
- credits=3, play → `start` high exactly 1 clk, credits=2. Bench drops `pause` for 50 clks then raises it with won=0 → `last_win`=0, credits=2, `busy`=0.
- credits=2, spin ends won=1, out=333 → `last_win`=1; credits rises 2→12 one step every 4 clks; `payout_active` drops when credits=12.
- Spin ends won=1, out=777 → `last_win`=2 and a +50 payout. With credits preset to 980 (after bet 979), credits stops at 999, remaining award is forfeited, state returns to IDLE.
- Play with credits=1, bench never drops `pause` → return to IDLE after 20 clks in WAIT_RUN, credits restored to 1. Play with credits=0 → no `start` pulse.
- Edge cases:
  - credits=999 plus coin edge → `coin_reject` pulse, credits=999.
  - Coin edge coinciding with a payout tick → credits +2.
  - `rst` asserted during PAYOUT → credits=0, IDLE, `start`=0 on the next clk.
